// File: rtl/regfile_pkg.sv
// regfile_pkg
//   Shared definitions for the register-file write side: widths, the
//   bulk-clear FSM state type and the one-entry write stage record.
//   Optional feature macro used by the top: REGFILE_BYPASS_EN.
package regfile_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NREGS  = 2 ** ADDR_W;
  localparam int CNT_W  = 16;

  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NREGS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } stage_t;

endpackage

// File: rtl/regfile_write_demux_decoder_5x32.sv
// decoder_5x32
//   Combinational ADDR_W-to-NREGS one-hot decoder; the inverse of the
//   32:1 read-select tree.
//   Ports:
//     idx    : register index to select
//     en     : when low, no output bit is set
//     onehot : one-hot write enables, bit k selects register k
module decoder_5x32
  import regfile_pkg::*;
(
  input  logic [ADDR_W-1:0] idx,
  input  logic              en,
  output logic [NREGS-1:0]  onehot
);

  always_comb begin
    onehot = '0;
    if (en) onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/regfile_write_demux.sv
// regfile_write_demux
//   Write side of the 32x32 register file. Writes arrive over a
//   valid/ready handshake, sit in a one-entry stage for one cycle and are
//   committed through a one-hot decoder. Register 0 is hardwired to zero.
//   A sequential bulk-clear FSM zeroes registers 1..NREGS-1, one per cycle.
//   Ports:
//     clk, reset          : clock, asynchronous active-high reset
//     wr_valid/wr_ready   : write handshake
//     wr_addr, wr_data    : write address / data
//     wr_ack              : pulse the cycle after a staged write commits
//     clr_req             : start a bulk clear (sampled in IDLE only)
//     clr_busy, clr_done  : clear in progress / clear finished pulse
//     wr_count            : saturating count of commits to nonzero registers
//     q_flat              : all registers, reg k at [k*DATA_W +: DATA_W]
//   Macro REGFILE_BYPASS_EN adds rd_addr/rd_data, a combinational read port
//   that forwards the staged write data.
module regfile_write_demux
  import regfile_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [ADDR_W-1:0]       wr_addr,
  input  logic [DATA_W-1:0]       wr_data,
  output logic                    wr_ack,
  input  logic                    clr_req,
  output logic                    clr_busy,
  output logic                    clr_done,
  output logic [CNT_W-1:0]        wr_count,
  output logic [NREGS*DATA_W-1:0] q_flat
`ifdef REGFILE_BYPASS_EN
  ,
  input  logic [ADDR_W-1:0]       rd_addr,
  output logic [DATA_W-1:0]       rd_data
`endif
);

  state_t            state_q, state_d;
  stage_t            stage_q, stage_d;
  logic [ADDR_W-1:0] clr_idx_q, clr_idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ack_q, ack_d;
  logic [DATA_W-1:0] regs_q [1:NREGS-1];
  logic [DATA_W-1:0] regs_d [1:NREGS-1];

  logic              sel_clear;
  logic [ADDR_W-1:0] dec_idx;
  logic              dec_en;
  logic [DATA_W-1:0] dec_data;
  logic [NREGS-1:0]  onehot;
  logic              accept;

  assign wr_ready = (state_q == ST_IDLE) && !clr_req;
  assign accept   = wr_valid && wr_ready;
  assign wr_ack   = ack_q;
  assign wr_count = cnt_q;
  assign clr_busy = (state_q == ST_CLEAR);
  assign clr_done = (state_q == ST_DONE);

  // One decoder serves both the commit path and the clear sweep. The stage
  // is always empty during CLEAR (wr_ready is low), so the two never collide.
  // Address 0 writes are simply not enabled, which keeps register 0 at zero.
  always_comb begin
    sel_clear = (state_q == ST_CLEAR);
    dec_idx   = sel_clear ? clr_idx_q : stage_q.addr;
    dec_en    = sel_clear || (stage_q.valid && (stage_q.addr != '0));
    dec_data  = sel_clear ? '0 : stage_q.data;
  end

  decoder_5x32 u_dec (
    .idx    (dec_idx),
    .en     (dec_en),
    .onehot (onehot)
  );

  always_comb begin
    for (int k = 1; k < NREGS; k++) begin
      regs_d[k] = onehot[k] ? dec_data : regs_q[k];
    end
  end

  // Stage, ack, counter and clear FSM. A staged write commits on the very
  // edge that enters CLEAR, but the counter reset takes priority there.
  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    cnt_d     = cnt_q;
    ack_d     = stage_q.valid;
    stage_d   = '{valid: accept, addr: wr_addr, data: wr_data};

    if (stage_q.valid && (stage_q.addr != '0) && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (clr_req) begin
          state_d   = ST_CLEAR;
          clr_idx_d = ADDR_W'(1);
          cnt_d     = '0;
        end
      end
      ST_CLEAR: begin
        // Stop at the last register so the index never wraps back to 0.
        if (clr_idx_q == LAST_IDX) state_d = ST_DONE;
        else                       clr_idx_d = clr_idx_q + ADDR_W'(1);
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      stage_q   <= '0;
      clr_idx_q <= '0;
      cnt_q     <= '0;
      ack_q     <= 1'b0;
      for (int k = 1; k < NREGS; k++) regs_q[k] <= '0;
    end else begin
      state_q   <= state_d;
      stage_q   <= stage_d;
      clr_idx_q <= clr_idx_d;
      cnt_q     <= cnt_d;
      ack_q     <= ack_d;
      for (int k = 1; k < NREGS; k++) regs_q[k] <= regs_d[k];
    end
  end

  always_comb begin
    q_flat = '0;
    for (int k = 1; k < NREGS; k++) begin
      q_flat[k*DATA_W +: DATA_W] = regs_q[k];
    end
  end

`ifdef REGFILE_BYPASS_EN
  // Forward the staged write so a read right after accept sees the new data.
  always_comb begin
    if (stage_q.valid && (stage_q.addr == rd_addr) && (rd_addr != '0)) begin
      rd_data = stage_q.data;
    end else begin
      rd_data = q_flat[rd_addr*DATA_W +: DATA_W];
    end
  end
`endif

endmodule

// File: tb/tb_regfile_write_demux.sv
// tb_regfile_write_demux
//   Self-checking bench for regfile_write_demux: directed scenarios followed
//   by randomized writes and clear requests, compared each cycle against a
//   behavioural model of the register file. Honours REGFILE_BYPASS_EN.
module tb_regfile_write_demux;
  import regfile_pkg::*;

  logic                    clk = 1'b0;
  logic                    reset;
  logic                    wr_valid;
  logic                    wr_ready;
  logic [ADDR_W-1:0]       wr_addr;
  logic [DATA_W-1:0]       wr_data;
  logic                    wr_ack;
  logic                    clr_req;
  logic                    clr_busy;
  logic                    clr_done;
  logic [CNT_W-1:0]        wr_count;
  logic [NREGS*DATA_W-1:0] q_flat;
`ifdef REGFILE_BYPASS_EN
  logic [ADDR_W-1:0]       rd_addr;
  logic [DATA_W-1:0]       rd_data;
  logic [ADDR_W-1:0]       rd_sel;
`endif

  int checks = 0;
  int errors = 0;

  // Model state: register contents, the write waiting to commit, and the
  // clear sequence (mode 0 idle, 1 clearing, 2 done).
  logic [DATA_W-1:0] mregs [NREGS];
  bit                pend_v;
  logic [ADDR_W-1:0] pend_a;
  logic [DATA_W-1:0] pend_d;
  int                mode;
  int                clr_next;
  int                mcnt;
  bit                mack;
  int                ack_seen, busy_seen, done_seen;

  always #5 clk = ~clk;

  regfile_write_demux dut (
    .clk      (clk),
    .reset    (reset),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_ack   (wr_ack),
    .clr_req  (clr_req),
    .clr_busy (clr_busy),
    .clr_done (clr_done),
    .wr_count (wr_count),
    .q_flat   (q_flat)
`ifdef REGFILE_BYPASS_EN
    ,
    .rd_addr  (rd_addr),
    .rd_data  (rd_data)
`endif
  );

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [DATA_W-1:0] regOf(input int k);
    return q_flat[k*DATA_W +: DATA_W];
  endfunction

  task automatic modelReset();
    for (int k = 0; k < NREGS; k++) mregs[k] = '0;
    pend_v = 0; pend_a = '0; pend_d = '0;
    mode = 0; clr_next = 0; mcnt = 0; mack = 0;
  endtask

  task automatic checkAll();
    for (int k = 0; k < NREGS; k++) begin
      checkOutput($sformatf("reg%0d", k), regOf(k), mregs[k]);
    end
    checkOutput("wr_ack", wr_ack, mack);
    checkOutput("wr_count", wr_count, mcnt);
    checkOutput("clr_busy", clr_busy, mode == 1);
    checkOutput("clr_done", clr_done, mode == 2);
  endtask

  // One clock of stimulus: drive at the falling edge, check the
  // combinational outputs, then advance the model across the rising edge.
  task automatic applyStimulus(input logic v, input logic [ADDR_W-1:0] a,
                               input logic [DATA_W-1:0] d, input logic c);
    bit exp_ready;
    bit acc;
`ifdef REGFILE_BYPASS_EN
    logic [DATA_W-1:0] exp_rd;
`endif
    @(negedge clk);
    wr_valid = v; wr_addr = a; wr_data = d; clr_req = c;
`ifdef REGFILE_BYPASS_EN
    rd_addr = rd_sel;
`endif
    #1;
    exp_ready = (mode == 0) && !c;
    checkOutput("wr_ready", wr_ready, exp_ready);
`ifdef REGFILE_BYPASS_EN
    if (rd_sel == 0)                      exp_rd = '0;
    else if (pend_v && pend_a == rd_sel)  exp_rd = pend_d;
    else                                  exp_rd = mregs[rd_sel];
    checkOutput("rd_data", rd_data, exp_rd);
`endif
    acc = v && exp_ready;
    @(posedge clk);
    mack = pend_v;
    if (pend_v && pend_a != 0) begin
      mregs[pend_a] = pend_d;
      if (mcnt < (1 << CNT_W) - 1) mcnt++;
    end
    case (mode)
      0: if (c) begin mode = 1; clr_next = 1; mcnt = 0; end
      1: begin
        mregs[clr_next] = '0;
        if (clr_next == NREGS - 1) mode = 2;
        else clr_next++;
      end
      default: mode = 0;
    endcase
    pend_v = acc; pend_a = a; pend_d = d;
    #1;
    checkAll();
    ack_seen  += int'(wr_ack);
    busy_seen += int'(clr_busy);
    done_seen += int'(clr_done);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1; wr_valid = 0; wr_addr = '0; wr_data = '0; clr_req = 0;
`ifdef REGFILE_BYPASS_EN
    rd_sel = '0; rd_addr = '0;
`endif
    modelReset();
    ack_seen = 0; busy_seen = 0; done_seen = 0;
    repeat (2) @(posedge clk);
    #1;
    checkAll();
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("ready_after_reset", wr_ready, 1'b1);

    // Single write to reg 5.
    ack_seen = 0;
    applyStimulus(1, 5, 32'hDEADBEEF, 0);
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("reg5_direct", regOf(5), 32'hDEADBEEF);
    checkOutput("count_first", wr_count, 1);
    checkOutput("acks_first", ack_seen, 1);

    // Back-to-back writes, same address twice.
    ack_seen = 0;
    applyStimulus(1, 3, 32'h1, 0);
    applyStimulus(1, 3, 32'h2, 0);
    applyStimulus(1, 7, 32'h3, 0);
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("reg3_b2b", regOf(3), 32'h2);
    checkOutput("reg7_b2b", regOf(7), 32'h3);
    checkOutput("acks_b2b", ack_seen, 3);
    checkOutput("count_b2b", wr_count, 4);

    // Write to register 0 is acked but discarded.
    ack_seen = 0;
    applyStimulus(1, 0, 32'hFFFFFFFF, 0);
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("reg0_zero", regOf(0), 32'h0);
    checkOutput("acks_addr0", ack_seen, 1);
    checkOutput("count_addr0", wr_count, 4);

    // Fill 1..31, then clear straight after the last write (it is lost),
    // with a write offered alongside the clear request (clear wins).
    for (int k = 1; k < NREGS; k++) applyStimulus(1, ADDR_W'(k), 32'h0101_0101 * k, 0);
    ack_seen = 0; busy_seen = 0; done_seen = 0;
    applyStimulus(1, 4, 32'h1234, 1);
    for (int i = 0; i < NREGS + 3; i++) applyStimulus(0, 0, 0, i < 5);
    checkOutput("clear_busy_cycles", busy_seen, NREGS - 1);
    checkOutput("clear_done_pulses", done_seen, 1);
    checkOutput("clear_last_ack", ack_seen, 1);
    checkOutput("clear_count", wr_count, 0);
    for (int k = 0; k < NREGS; k++) checkOutput($sformatf("cleared%0d", k), regOf(k), 32'h0);

    // Reset during the tenth clear cycle aborts everything at once.
    applyStimulus(1, 12, 32'h55AA55AA, 0);
    applyStimulus(0, 0, 0, 1);
    for (int i = 0; i < 9; i++) applyStimulus(0, 0, 0, 0);
    checkOutput("busy_before_reset", clr_busy, 1'b1);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    modelReset();
    checkAll();
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("ready_after_abort", wr_ready, 1'b1);

`ifdef REGFILE_BYPASS_EN
    // Forwarding from the stage before the write commits.
    rd_sel = 9;
    applyStimulus(1, 9, 32'hA5A5A5A5, 0);
    checkOutput("bypass_9", rd_data, 32'hA5A5A5A5);
    checkOutput("bypass_9_not_committed", regOf(9), 32'h0);
    rd_addr = 0;
    #1;
    checkOutput("bypass_0", rd_data, 32'h0);
    applyStimulus(0, 0, 0, 0);
`endif

    // Randomized traffic, including clear requests while already clearing.
    for (int i = 0; i < 500; i++) begin
`ifdef REGFILE_BYPASS_EN
      rd_sel = ($urandom_range(0, 1) == 0) ? pend_a : ADDR_W'($urandom_range(0, NREGS - 1));
`endif
      applyStimulus($urandom_range(0, 3) != 0,
                    ($urandom_range(0, 7) == 0) ? '0 : ADDR_W'($urandom_range(0, NREGS - 1)),
                    DATA_W'($urandom),
                    $urandom_range(0, 59) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
